// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   - lsu_state_e    : controller states (IDLE, RD, WR, DONE)
//   - F3_*           : RISC-V funct3 size/sign codes for loads and stores
//   - lsu_nbytes()   : funct3[1:0] -> access size in bytes (1/2/4/8)
//   - lsu_byte_mask(): funct3[1:0] -> mask covering the low N bytes
package lsu_pkg;

   localparam int LSU_XLEN = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Loads
   localparam logic [2:0] F3_LB      = 3'b000;
   localparam logic [2:0] F3_LH      = 3'b001;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_LD      = 3'b011;
   localparam logic [2:0] F3_LBU     = 3'b100;
   localparam logic [2:0] F3_LHU     = 3'b101;
   localparam logic [2:0] F3_LWU     = 3'b110;
   localparam logic [2:0] F3_ILLEGAL = 3'b111;
   // Stores share the low two bits with the loads; funct3[2] must be 0.
   localparam logic [1:0] SZ_DWORD   = 2'b11;

   function automatic int unsigned lsu_nbytes(input logic [1:0] size);
      return 32'd1 << size;
   endfunction

   function automatic logic [LSU_XLEN-1:0] lsu_byte_mask(input logic [1:0] size);
      int unsigned nb;
      nb = lsu_nbytes(size);
      if (nb == 32'd8) begin
         return '1;
      end
      return (64'd1 << (8 * nb)) - 64'd1;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store controller.
// Ports:
//   funct3_i     : latched funct3 of the current operation
//   mem_rdata_i  : 8 bytes returned by memory, little-endian
//   wdata_i      : latched store data (low bytes used)
//   load_data_o  : low N bytes of mem_rdata_i, sign/zero extended per funct3
//   merge_data_o : mem_rdata_i with its low N bytes replaced by wdata_i
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]          funct3_i,
   input  logic [LSU_XLEN-1:0] mem_rdata_i,
   input  logic [LSU_XLEN-1:0] wdata_i,
   output logic [LSU_XLEN-1:0] load_data_o,
   output logic [LSU_XLEN-1:0] merge_data_o
);

   logic [LSU_XLEN-1:0] mask;

   assign mask = lsu_byte_mask(funct3_i[1:0]);

   always_comb begin
      load_data_o = mem_rdata_i;
      unique case (funct3_i)
         F3_LB:   load_data_o = {{56{mem_rdata_i[7]}},  mem_rdata_i[7:0]};
         F3_LH:   load_data_o = {{48{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
         F3_LW:   load_data_o = {{32{mem_rdata_i[31]}}, mem_rdata_i[31:0]};
         F3_LD:   load_data_o = mem_rdata_i;
         F3_LBU:  load_data_o = {56'd0, mem_rdata_i[7:0]};
         F3_LHU:  load_data_o = {48'd0, mem_rdata_i[15:0]};
         F3_LWU:  load_data_o = {32'd0, mem_rdata_i[31:0]};
         default: load_data_o = mem_rdata_i;   // illegal code never reaches RD
      endcase
   end

   assign merge_data_o = (mem_rdata_i & ~mask) | (wdata_i & mask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one load or store from the core, runs a
// req/ack transaction on the 8-byte-wide data memory port and returns the
// extended load result. Sub-dword stores are read-modify-write.
// Ports:
//   in_clk, in_rst          : clock (rising edge), async active-high reset
//   in_start                : start request, sampled only in IDLE
//   in_is_store, in_funct3  : operation kind and RISC-V size/sign code
//   in_addr, in_wdata       : byte address and store data
//   out_busy                : state is not IDLE
//   out_done, out_fault     : one-cycle completion pulse and its fault flag
//   out_rdata               : last load result, held until the next load
//   out_mem_req/we/addr/wdata : registered memory request
//   in_mem_rdata, in_mem_ack  : memory read data and acknowledge
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int              DATA_WIDTH = 64,
   parameter longint unsigned MEM_BYTES  = 1048576
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_start,
   input  logic                  in_is_store,
   input  logic [2:0]            in_funct3,
   input  logic [DATA_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   output logic                  out_busy,
   output logic                  out_done,
   output logic [DATA_WIDTH-1:0] out_rdata,
   output logic                  out_fault,
   output logic                  out_mem_req,
   output logic                  out_mem_we,
   output logic [DATA_WIDTH-1:0] out_mem_addr,
   output logic [DATA_WIDTH-1:0] out_mem_wdata,
   input  logic [DATA_WIDTH-1:0] in_mem_rdata,
   input  logic                  in_mem_ack
);

   // Highest legal start address: the 8-byte transfer must fit in memory.
   localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_BYTES - 64'd8);

   lsu_state_e            state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic                  store_q, store_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  fault_q, fault_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;

   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_data;
   logic                  start_fault;
   logic                  ack_seen;

   lsu_align u_align (
      .funct3_i     (funct3_q),
      .mem_rdata_i  (in_mem_rdata),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .merge_data_o (merge_data)
   );

   assign start_fault = (in_is_store ? in_funct3[2] : (in_funct3 == F3_ILLEGAL))
                      | (in_addr > LAST_ADDR);

   // Ack counts only while a request is actually outstanding.
   assign ack_seen = req_q & in_mem_ack;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q  <= ST_IDLE;
         funct3_q <= '0;
         store_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         store_q  <= store_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         req_q    <= req_d;
         we_q     <= we_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      funct3_d = funct3_q;
      store_d  = store_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      req_d    = req_q;
      we_d     = we_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               funct3_d = in_funct3;
               store_d  = in_is_store;
               wdata_d  = in_wdata;
               maddr_d  = in_addr;
               fault_d  = start_fault;
               if (start_fault) begin
                  state_d = ST_DONE;
               end else if (in_is_store && (in_funct3[1:0] == SZ_DWORD)) begin
                  // Full doubleword store needs no read.
                  state_d  = ST_WR;
                  req_d    = 1'b1;
                  we_d     = 1'b1;
                  mwdata_d = in_wdata;
               end else begin
                  state_d = ST_RD;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
               end
            end
         end

         ST_RD: begin
            if (ack_seen) begin
               req_d = 1'b0;
               if (store_q) begin
                  // WR is entered with req low, giving the mandatory gap cycle.
                  mwdata_d = merge_data;
                  state_d  = ST_WR;
               end else begin
                  rdata_d = load_data;
                  state_d = ST_DONE;
               end
            end
         end

         ST_WR: begin
            if (!req_q) begin
               req_d = 1'b1;
               we_d  = 1'b1;
            end else if (in_mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            fault_d = 1'b0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign out_busy      = (state_q != ST_IDLE);
   assign out_done      = (state_q == ST_DONE);
   assign out_fault     = fault_q;
   assign out_rdata     = rdata_q;
   assign out_mem_req   = req_q;
   assign out_mem_we    = we_q;
   assign out_mem_addr  = maddr_q;
   assign out_mem_wdata = mwdata_q;

endmodule
